// File: rtl/play_pkg.sv
`default_nettype none
// ============================================================================
// Module      : play_pkg
// Description : Shared constants, error codes and state encodings for the
//               serial move receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package play_pkg;

    localparam logic [7:0] CHAR_INICIO     = 8'h23;
    localparam logic [7:0] CHAR_FIM        = 8'h0A;
    localparam logic [7:0] CHAR_DIGITO_MIN = 8'h30;
    localparam logic [7:0] CHAR_DIGITO_MAX = 8'h39;

    localparam logic [1:0] ERR_NENHUM  = 2'b00;
    localparam logic [1:0] ERR_CHAR    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OCUPADO = 2'b11;

    typedef enum logic [3:0] {
        AGUARDA_INICIO = 4'b0000,
        RECEBE_DIGITO  = 4'b0001,
        AGUARDA_FIM    = 4'b0010,
        VALIDA         = 4'b0011,
        ERRO_STATE     = 4'b0100
    } estado_t;

    function automatic logic eh_digito(input logic [7:0] c);
        return (c >= CHAR_DIGITO_MIN) && (c <= CHAR_DIGITO_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/play_receiver_timer.sv
`default_nettype none
// ============================================================================
// Module      : play_receiver_timer
// Description : Inter-character idle counter; fim flags the cycle in which
//               the count would reach TIMEOUT_CICLOS.
// Revision    : 1.0 - initial release
// ============================================================================
module play_receiver_timer #(
    parameter int TIMEOUT_CICLOS = 5_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CICLOS);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    // Expiry is flagged from the next count so the FSM leaves on the same
    // edge the counter reaches the limit; a clear (new character) wins.
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (clear) begin
            w_cnt_d = '0;
        end else if (enable) begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end
        fim = enable && !clear && (w_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/play_receiver.sv
`default_nettype none
// ============================================================================
// Module      : play_receiver
// Description : Parses '#' + N digits + '\n' frames from the UART RX and
//               emits the decoded move or an error code.
// Revision    : 1.0 - initial release
// ============================================================================
module play_receiver
    import play_pkg::*;
#(
    parameter int N_DIGITOS      = 4,
    parameter int TIMEOUT_CICLOS = 5_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pronto_rx,
    input  logic [7:0]             dado_rx,
    input  logic                   ocupado,
    output logic [4*N_DIGITOS-1:0] jogada,
    output logic                   jogada_valida,
    output logic                   erro,
    output logic [1:0]             erro_codigo,
    output logic                   recebendo,
    output logic [3:0]             db_estado
);

    localparam int               BUF_W   = 4 * N_DIGITOS;
    localparam int               IDX_W   = $clog2(N_DIGITOS + 1);
    localparam logic [IDX_W-1:0] IDX_ULT = IDX_W'(N_DIGITOS - 1);

    estado_t          r_estado_q, w_estado_d;
    logic [IDX_W-1:0] r_idx_q, w_idx_d;
    logic [BUF_W-1:0] r_buf_q, w_buf_d;
    logic [BUF_W-1:0] r_jogada_q, w_jogada_d;
    logic             r_valida_q, w_valida_d;
    logic             r_erro_q, w_erro_d;
    logic [1:0]       r_codigo_q, w_codigo_d;
    logic             r_recebendo_q, w_recebendo_d;
    logic [1:0]       w_causa;

    logic w_em_quadro;
    logic w_tmr_fim;

    assign w_em_quadro = (r_estado_q == RECEBE_DIGITO) || (r_estado_q == AGUARDA_FIM);

    play_receiver_timer #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (pronto_rx || !w_em_quadro),
        .enable (w_em_quadro),
        .fim    (w_tmr_fim)
    );

    always_comb begin
        w_estado_d = r_estado_q;
        w_idx_d    = r_idx_q;
        w_buf_d    = r_buf_q;
        w_causa    = ERR_NENHUM;

        case (r_estado_q)
            AGUARDA_INICIO: begin
                if (pronto_rx && (dado_rx == CHAR_INICIO)) begin
                    w_idx_d    = '0;
                    w_buf_d    = '0;
                    w_estado_d = RECEBE_DIGITO;
                end
            end
            RECEBE_DIGITO: begin
                if (pronto_rx) begin
                    if (eh_digito(dado_rx)) begin
                        // Low nibble of an ASCII digit is its value
                        w_buf_d = (r_buf_q << 4) | BUF_W'(dado_rx[3:0]);
                        w_idx_d = r_idx_q + IDX_W'(1);
                        if (r_idx_q == IDX_ULT) begin
                            w_estado_d = AGUARDA_FIM;
                        end
                    end else if (dado_rx == CHAR_INICIO) begin
                        w_idx_d = '0;
                        w_buf_d = '0;
                    end else begin
                        w_causa    = ERR_CHAR;
                        w_estado_d = ERRO_STATE;
                    end
                end else if (w_tmr_fim) begin
                    w_causa    = ERR_TIMEOUT;
                    w_estado_d = ERRO_STATE;
                end
            end
            AGUARDA_FIM: begin
                if (pronto_rx) begin
                    if (dado_rx == CHAR_FIM) begin
                        if (ocupado) begin
                            w_causa    = ERR_OCUPADO;
                            w_estado_d = ERRO_STATE;
                        end else begin
                            w_estado_d = VALIDA;
                        end
                    end else if (dado_rx == CHAR_INICIO) begin
                        w_idx_d    = '0;
                        w_buf_d    = '0;
                        w_estado_d = RECEBE_DIGITO;
                    end else begin
                        w_causa    = ERR_CHAR;
                        w_estado_d = ERRO_STATE;
                    end
                end else if (w_tmr_fim) begin
                    w_causa    = ERR_TIMEOUT;
                    w_estado_d = ERRO_STATE;
                end
            end
            VALIDA:     w_estado_d = AGUARDA_INICIO;
            ERRO_STATE: w_estado_d = AGUARDA_INICIO;
            default:    w_estado_d = AGUARDA_INICIO;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        w_valida_d    = (w_estado_d == VALIDA);
        w_erro_d      = (w_estado_d == ERRO_STATE);
        w_recebendo_d = (w_estado_d == RECEBE_DIGITO) || (w_estado_d == AGUARDA_FIM);
        w_jogada_d    = w_valida_d ? w_buf_d : r_jogada_q;
        w_codigo_d    = w_erro_d ? w_causa : r_codigo_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado_q    <= AGUARDA_INICIO;
            r_idx_q       <= '0;
            r_buf_q       <= '0;
            r_jogada_q    <= '0;
            r_valida_q    <= 1'b0;
            r_erro_q      <= 1'b0;
            r_codigo_q    <= ERR_NENHUM;
            r_recebendo_q <= 1'b0;
        end else begin
            r_estado_q    <= w_estado_d;
            r_idx_q       <= w_idx_d;
            r_buf_q       <= w_buf_d;
            r_jogada_q    <= w_jogada_d;
            r_valida_q    <= w_valida_d;
            r_erro_q      <= w_erro_d;
            r_codigo_q    <= w_codigo_d;
            r_recebendo_q <= w_recebendo_d;
        end
    end

    assign jogada        = r_jogada_q;
    assign jogada_valida = r_valida_q;
    assign erro          = r_erro_q;
    assign erro_codigo   = r_codigo_q;
    assign recebendo     = r_recebendo_q;
    assign db_estado     = r_estado_q;

endmodule
`default_nettype wire
